// File: rtl/call_stack_pkg.sv
// call_stack_pkg: shared sizing and operation decode for the Fibonacci call stack
// Provides:
//   FIB_WIDTH, STACK_DEPTH, STACK_AW  datapath word width and stack geometry
//   stack_op_e                        the single action taken on a clock edge
//   decode_op()                       maps push/pop plus boundary state to that action
package call_stack_pkg;

    localparam int FIB_WIDTH   = 8;
    localparam int STACK_DEPTH = 16;
    localparam int STACK_AW    = 4;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_OVF,
        OP_UNF
    } stack_op_e;

    // Push together with pop replaces the top, except on an empty stack where it is a plain push.
    function automatic stack_op_e decode_op(input logic push, input logic pop,
                                            input logic full, input logic empty);
        return (!push && !pop)         ? OP_HOLD :
               (push && pop && !empty) ? OP_REPL :
               push                    ? (full ? OP_OVF : OP_PUSH) :
                                         (empty ? OP_UNF : OP_POP);
    endfunction

endpackage

// File: rtl/call_stack_ram.sv
// stack_ram: DEPTH x WIDTH frame storage, one synchronous write port, one asynchronous read port
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// call_stack: bounded LIFO frame store for the recursive Fibonacci datapath
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   push     in   write din as new top of stack
//   pop      in   remove current top of stack
//   din      in   data to push
//   dout     out  show-ahead top-of-stack word, 0 when empty
//   empty    out  count == 0
//   full     out  count == DEPTH
//   count    out  stored word count, 0..DEPTH
//   ovf      out  sticky: push attempted while full
//   unf      out  sticky: pop attempted while empty
//   err_clr  in   synchronous clear of ovf/unf; a same-cycle error still sets its flag
module call_stack
    import call_stack_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = STACK_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             unf,
    input  logic             err_clr
);

    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    stack_op_e        op;
    logic             we;
    logic [AW-1:0]    waddr, top_addr;
    logic [WIDTH-1:0] rdata;

    assign empty    = count_q == '0;
    assign full     = count_q == (AW+1)'(DEPTH);
    // Truncation is safe: when count is DEPTH the top index DEPTH-1 still fits in AW bits.
    assign top_addr = AW'(count_q - 1'b1);

    always_comb begin
        op      = decode_op(push, pop, full, empty);
        we      = op == OP_PUSH || op == OP_REPL;
        waddr   = op == OP_REPL ? top_addr : count_q[AW-1:0];
        count_d = op == OP_PUSH ? count_q + 1'b1 : op == OP_POP ? count_q - 1'b1 : count_q;
        ovf_d   = op == OP_OVF || (ovf_q && !err_clr);
        unf_d   = op == OP_UNF || (unf_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(din),
        .raddr(top_addr),
        .rdata(rdata)
    );

    // Storage is not reset, so mask the read while empty.
    assign dout  = empty ? '0 : rdata;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
